// File: rtl/boot_loader_sequencer_if.sv
// Byte-link and program-memory write bus used by the boot loader sequencer.
//   rx_valid/rx_data     : received UART byte, one-cycle pulse, no backpressure
//   tx_valid/tx_data     : byte offered to the UART transmitter
//   tx_ready             : transmitter accepts the offered byte this cycle
//   program_memory_write_*: one-cycle word write strobe, word address, data
// master: the sequencer side.  slave: the UART / memory environment side.
interface boot_loader_sequencer_if #(
    parameter int unsigned PROGRAM_MEMORY_ADDRESS_BITWIDTH = 15
);
    logic                                       rx_valid;
    logic [7:0]                                 rx_data;
    logic                                       tx_ready;
    logic                                       tx_valid;
    logic [7:0]                                 tx_data;
    logic                                       program_memory_write_enable;
    logic [PROGRAM_MEMORY_ADDRESS_BITWIDTH-1:0] program_memory_write_address;
    logic [31:0]                                program_memory_write_data;

    modport master (
        input  rx_valid,
        input  rx_data,
        input  tx_ready,
        output tx_valid,
        output tx_data,
        output program_memory_write_enable,
        output program_memory_write_address,
        output program_memory_write_data
    );

    modport slave (
        output rx_valid,
        output rx_data,
        output tx_ready,
        input  tx_valid,
        input  tx_data,
        input  program_memory_write_enable,
        input  program_memory_write_address,
        input  program_memory_write_data
    );
endinterface

// File: rtl/boot_loader_sequencer.sv
// Power-up program loader over the UART byte link.
// Sends 0x99, receives a 32-bit little-endian byte count, streams that many bytes into
// program memory as little-endian 32-bit words, sends 0xAA, then holds boot_done.
// Ports:
//   clk, reset_n : clock and asynchronous active-low reset
//   restart      : pulse, honoured only once loading is done; reruns the whole sequence
//   bus          : byte link and program-memory write port (master side)
//   loading      : high while receiving the size and the program
//   overflow     : sticky, program exceeded 2^W words (excess writes dropped)
//   boot_done    : high once the 0xAA acknowledge has been accepted
// The interface instance must use the same PROGRAM_MEMORY_ADDRESS_BITWIDTH as this module.
module boot_loader_sequencer #(
    parameter int unsigned PROGRAM_MEMORY_ADDRESS_BITWIDTH = 15
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           restart,
    boot_loader_sequencer_if.master        bus,
    output logic                           loading,
    output logic                           overflow,
    output logic                           boot_done
);
    localparam int unsigned W = PROGRAM_MEMORY_ADDRESS_BITWIDTH;

    typedef enum logic [2:0] {
        StReset,
        StSend99,
        StRecvSize,
        StRecvProg,
        StSendAa,
        StDone
    } state_e;

    state_e         state_q;
    logic [31:0]    size_q;
    logic [31:0]    byte_cnt_q;
    logic [31:0]    word_q;
    logic [W-1:0]   addr_q;
    logic           addr_full_q;  // every address has been written; further words overflow
    logic           last_q;       // final byte taken; its write cycle is in progress

    logic [31:0]    byte_cnt_inc;
    logic [31:0]    word_merged;
    logic [31:0]    size_merged;
    logic           final_byte;
    logic           word_complete;

    always_comb begin
        byte_cnt_inc  = byte_cnt_q + 32'd1;
        // Lane comes from the byte counter; the word register is cleared after every write,
        // so a short final word keeps its unreceived upper bytes zero.
        word_merged   = word_q | ({24'd0, bus.rx_data} << {byte_cnt_q[1:0], 3'b000});
        size_merged   = {bus.rx_data, size_q[23:0]};
        final_byte    = (byte_cnt_inc == size_q);
        word_complete = (byte_cnt_q[1:0] == 2'd3);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q                          <= StReset;
            size_q                           <= '0;
            byte_cnt_q                       <= '0;
            word_q                           <= '0;
            addr_q                           <= '0;
            addr_full_q                      <= 1'b0;
            last_q                           <= 1'b0;
            bus.tx_valid                     <= 1'b0;
            bus.tx_data                      <= 8'h00;
            bus.program_memory_write_enable  <= 1'b0;
            bus.program_memory_write_address <= '0;
            bus.program_memory_write_data    <= '0;
            loading                          <= 1'b0;
            overflow                         <= 1'b0;
            boot_done                        <= 1'b0;
        end else begin
            bus.program_memory_write_enable <= 1'b0;
            unique case (state_q)
                StReset: begin
                    state_q      <= StSend99;
                    bus.tx_valid <= 1'b1;
                    bus.tx_data  <= 8'h99;
                end
                StSend99: begin
                    if (bus.tx_ready) begin
                        state_q      <= StRecvSize;
                        bus.tx_valid <= 1'b0;
                        bus.tx_data  <= 8'h00;
                        loading      <= 1'b1;
                    end
                end
                StRecvSize: begin
                    if (bus.rx_valid) begin
                        size_q[{byte_cnt_q[1:0], 3'b000} +: 8] <= bus.rx_data;
                        if (byte_cnt_q[1:0] == 2'd3) begin
                            byte_cnt_q <= '0;
                            if (size_merged != 32'd0) begin
                                state_q <= StRecvProg;
                            end else begin
                                state_q      <= StSendAa;
                                bus.tx_valid <= 1'b1;
                                bus.tx_data  <= 8'hAA;
                                loading      <= 1'b0;
                            end
                        end else begin
                            byte_cnt_q <= byte_cnt_inc;
                        end
                    end
                end
                StRecvProg: begin
                    if (last_q) begin
                        // Edge ending the final write cycle; the counter equals size, so
                        // no further bytes are taken.
                        last_q       <= 1'b0;
                        state_q      <= StSendAa;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= 8'hAA;
                        loading      <= 1'b0;
                    end else if (bus.rx_valid) begin
                        byte_cnt_q <= byte_cnt_inc;
                        if (word_complete || final_byte) begin
                            word_q <= '0;
                            if (addr_full_q) begin
                                overflow <= 1'b1;
                            end else begin
                                bus.program_memory_write_enable  <= 1'b1;
                                bus.program_memory_write_address <= addr_q;
                                bus.program_memory_write_data    <= word_merged;
                                addr_q                           <= addr_q + 1'b1;
                                if (&addr_q) begin
                                    addr_full_q <= 1'b1;
                                end
                            end
                            if (final_byte) begin
                                last_q <= 1'b1;
                            end
                        end else begin
                            word_q <= word_merged;
                        end
                    end
                end
                StSendAa: begin
                    if (bus.tx_ready) begin
                        state_q      <= StDone;
                        bus.tx_valid <= 1'b0;
                        bus.tx_data  <= 8'h00;
                        boot_done    <= 1'b1;
                    end
                end
                StDone: begin
                    if (restart) begin
                        state_q      <= StSend99;
                        size_q       <= '0;
                        byte_cnt_q   <= '0;
                        word_q       <= '0;
                        addr_q       <= '0;
                        addr_full_q  <= 1'b0;
                        last_q       <= 1'b0;
                        overflow     <= 1'b0;
                        boot_done    <= 1'b0;
                        bus.tx_valid <= 1'b1;
                        bus.tx_data  <= 8'h99;
                    end
                end
                default: begin
                    state_q <= StReset;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_boot_loader_sequencer.sv
// Self-checking bench for boot_loader_sequencer (W=2 so overflow is reachable).
// Stimulus pushes expected transmit bytes and memory writes into a scoreboard queue;
// a negedge monitor pops and compares every observed transfer and write strobe.
module tb_boot_loader_sequencer;
    localparam int unsigned W = 2;

    logic clk;
    logic reset_n;
    logic restart;
    logic loading;
    logic overflow;
    logic boot_done;

    boot_loader_sequencer_if #(.PROGRAM_MEMORY_ADDRESS_BITWIDTH(W)) bus ();

    boot_loader_sequencer #(.PROGRAM_MEMORY_ADDRESS_BITWIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .restart   (restart),
        .bus       (bus),
        .loading   (loading),
        .overflow  (overflow),
        .boot_done (boot_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          is_write;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, req, $time);
        end
    endfunction

    // Monitor: transfers and writes are sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (bus.program_memory_write_enable === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%08h at %0t",
                         bus.program_memory_write_address, bus.program_memory_write_data,
                         $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (!e.is_write || bus.program_memory_write_address !== e.addr[W-1:0] ||
                    bus.program_memory_write_data !== e.data) begin
                    bad++;
                    $display("FAIL write: got addr 0x%0h data 0x%08h want %s addr 0x%0h data 0x%08h at %0t",
                             bus.program_memory_write_address, bus.program_memory_write_data,
                             e.is_write ? "write" : "tx", e.addr, e.data, $time);
                end
            end
        end
        if (bus.tx_valid === 1'b1 && bus.tx_ready === 1'b1) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_tx: byte 0x%02h at %0t", bus.tx_data, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (e.is_write || {24'd0, bus.tx_data} !== e.data) begin
                    bad++;
                    $display("FAIL tx: got byte 0x%02h want %s 0x%08h at %0t",
                             bus.tx_data, e.is_write ? "write" : "tx", e.data, $time);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.is_write = 1'b1;
        e.addr     = a;
        e.data     = d;
        exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic send_size(input logic [31:0] s);
        for (int i = 0; i < 4; i++) begin
            send_byte(s[8*i +: 8]);
        end
    endtask

    // Expect one transfer of byte b within a bounded number of cycles.
    task automatic wait_tx(input logic [7:0] b);
        exp_t e;
        bit   seen;
        e.is_write = 1'b0;
        e.addr     = '0;
        e.data     = {24'd0, b};
        exp_q.push_back(e);
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            if (bus.tx_valid && bus.tx_ready) seen = 1'b1;
            tick();
        end
        chk("tx_handshake_seen", {31'd0, seen}, 32'd1);
    endtask

    task automatic do_restart();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk("restart_boot_done_low", {31'd0, boot_done}, 32'd0);
        wait_tx(8'h99);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_tx_valid"}, {31'd0, bus.tx_valid}, 32'd0);
        chk({tag, "_tx_data"}, {24'd0, bus.tx_data}, 32'd0);
        chk({tag, "_we"}, {31'd0, bus.program_memory_write_enable}, 32'd0);
        chk({tag, "_addr"}, {30'd0, bus.program_memory_write_address}, 32'd0);
        chk({tag, "_data"}, bus.program_memory_write_data, 32'd0);
        chk({tag, "_flags"}, {29'd0, loading, overflow, boot_done}, 32'd0);
    endtask

    logic [7:0] normal_bytes [8];
    logic [7:0] partial_bytes [6];

    initial begin
        normal_bytes  = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
        partial_bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

        reset_n      = 1'b0;
        restart      = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b0;
        repeat (3) tick();
        chk_reset_outputs("reset");

        // Release, then stall the 0x99 for 10 cycles.
        reset_n = 1'b1;
        tick();
        chk("first_cycle_tx_valid", {31'd0, bus.tx_valid}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("stall_tx_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'h99});
        end
        bus.tx_ready = 1'b1;
        wait_tx(8'h99);
        chk("tx_valid_drops", {31'd0, bus.tx_valid}, 32'd0);
        chk("loading_in_size", {31'd0, loading}, 32'd1);

        // Normal load, bytes back to back.
        send_size(32'd8);
        push_write(32'd0, 32'h0010_0513);
        push_write(32'd1, 32'h0020_0593);
        for (int i = 0; i < 8; i++) begin
            send_byte(normal_bytes[i]);
            if (i == 3) chk("write_latency_hi", {31'd0, bus.program_memory_write_enable}, 32'd1);
            if (i == 4) chk("write_one_cycle", {31'd0, bus.program_memory_write_enable}, 32'd0);
        end
        wait_tx(8'hAA);
        chk("normal_boot_done", {30'd0, boot_done, loading}, 32'd2);

        // Zero-length program.
        do_restart();
        send_size(32'd0);
        chk("size0_aa_offered", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, 8'hAA});
        chk("size0_loading_low", {31'd0, loading}, 32'd0);
        wait_tx(8'hAA);
        chk("size0_boot_done", {31'd0, boot_done}, 32'd1);

        // Partial final word.
        do_restart();
        send_size(32'd6);
        push_write(32'd0, 32'h4433_2211);
        push_write(32'd1, 32'h0000_6655);
        for (int i = 0; i < 6; i++) send_byte(partial_bytes[i]);
        wait_tx(8'hAA);
        chk("partial_boot_done", {31'd0, boot_done}, 32'd1);

        // Overflow: 20 bytes into a 4-word memory.
        do_restart();
        send_size(32'd20);
        push_write(32'd0, 32'h0403_0201);
        push_write(32'd1, 32'h0807_0605);
        push_write(32'd2, 32'h0c0b_0a09);
        push_write(32'd3, 32'h100f_0e0d);
        for (int i = 0; i < 20; i++) begin
            send_byte(8'(i + 1));
            if (i == 15) chk("overflow_not_yet", {31'd0, overflow}, 32'd0);
        end
        chk("overflow_set", {30'd0, overflow, bus.program_memory_write_enable}, 32'd2);
        wait_tx(8'hAA);
        chk("overflow_sticky_done", {30'd0, overflow, boot_done}, 32'd3);
        do_restart();
        chk("overflow_cleared", {31'd0, overflow}, 32'd0);

        // Reset in the middle of the program bytes.
        send_size(32'd8);
        for (int i = 0; i < 3; i++) send_byte(normal_bytes[i]);
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick();
        reset_n = 1'b1;
        tick();
        wait_tx(8'h99);
        send_size(32'd4);
        push_write(32'd0, 32'h1234_5678);
        send_byte(8'h78);
        send_byte(8'h56);
        send_byte(8'h34);
        send_byte(8'h12);
        wait_tx(8'hAA);
        chk("fresh_load_boot_done", {31'd0, boot_done}, 32'd1);

        repeat (3) tick();
        chk("scoreboard_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/boot_loader_sequencer.md
# boot_loader_sequencer

Sequences the CPU's power-up program load over the UART byte link. The block sends the 0x99 handshake byte, receives a 32-bit program size, streams the program bytes into program memory as little-endian 32-bit words, then sends the 0xAA acknowledge. It then raises `boot_done` so the state controller can release the pipeline. It sits between the UART byte transmitter/receiver and the program memory write port, and owns that write port until loading completes.

## Interface

Parameters:

- `PROGRAM_MEMORY_ADDRESS_BITWIDTH`, default 15: word-address width of program memory. Capacity is 2^W words.

Ports:

- `clk` input 1: the single clock. All state changes on its rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `restart` input 1: single-cycle pulse. Honoured only in state DONE.
- `rx_valid` input 1: one-cycle pulse; `rx_data` holds a received byte. No backpressure.
- `rx_data` input 8: received byte.
- `tx_ready` input 1: transmitter can accept a byte this cycle.
- `tx_valid` output 1: byte offered on `tx_data`.
- `tx_data` output 8: byte to transmit.
- `program_memory_write_enable` output 1: one-cycle write strobe.
- `program_memory_write_address` output W: word address.
- `program_memory_write_data` output 32: word to write.
- `loading` output 1: high in RECV_SIZE and RECV_PROG.
- `overflow` output 1: sticky. Set when program bytes exceed capacity.
- `boot_done` output 1: high in DONE.

## Operation

- States: RESET → SEND_99 → RECV_SIZE → RECV_PROG → SEND_AA → DONE.
- RESET: entered while `reset_n`=0. Moves to SEND_99 on the first edge after release.
- SEND_99: `tx_valid`=1, `tx_data`=0x99. Held until an edge with `tx_ready`=1, then go to RECV_SIZE.
- RECV_SIZE:
  - Collects 4 `rx_valid` bytes, little-endian, into `size` (32-bit byte count).
  - After the 4th byte: go to RECV_PROG if `size`≠0, else SEND_AA.
- RECV_PROG:
  - Shifts each byte into a 32-bit word register, little-endian: byte k of a word lands in bits [8k+7:8k].
  - A 32-bit byte counter increments per byte.
  - When a word completes, or the final byte arrives (counter = `size`), issue a write on the next cycle.
  - A partial final word has its unreceived upper bytes zero.
  - Word address starts at 0 and increments after each write.
  - If the word address ≥ 2^W: suppress the write, set `overflow`, keep consuming bytes.
  - After the final byte's write cycle, go to SEND_AA.
- SEND_AA: same as SEND_99 with 0xAA. On acceptance, go to DONE.
- DONE: `boot_done`=1. A `restart` pulse returns to SEND_99, clearing the counters, address and `overflow`.
- `rx_valid` outside RECV_SIZE/RECV_PROG is ignored.
- `restart` outside DONE is ignored.
- The size compare uses the full 32 bits. The byte counter never wraps, because it stops at `size`.

## Timing

- Reset values, asynchronous: state RESET.
  - Outputs: `tx_valid`=0, `tx_data`=0x00, `program_memory_write_enable`=0, address 0, data 0.
  - Flags: `loading`=0, `overflow`=0, `boot_done`=0.
  - Registers: `size`=0, counters 0.
- First cycle after release: state SEND_99, `tx_valid`=1.
- Transmit handshake:
  - A byte is transferred on an edge where `tx_valid` and `tx_ready` are both 1.
  - `tx_data` stays stable while `tx_valid`=1 and `tx_ready`=0.
  - `tx_valid` drops on the cycle after transfer.
- Write latency:
  - `program_memory_write_enable` is registered.
  - It is high exactly one cycle, the cycle after the edge that sampled the completing byte.
  - Address and data are valid in that same cycle.
- Back-to-back bytes (`rx_valid` every cycle) must be sustained with no loss. A write cycle overlapping the next byte's arrival is legal.
- SEND_AA is entered on the edge ending the last write cycle. When `size`=0, it is entered on the edge after the 4th size byte.
- `boot_done` rises the cycle after the 0xAA transfer.
- Reset mid-operation: returns immediately to RESET values. Any in-flight `program_memory_write_enable` is deasserted asynchronously.

## Test plan

- Normal load:
  - Stimulus: accept 0x99; size bytes 08 00 00 00; program bytes 13 05 10 00 93 05 20 00; `tx_ready` always high.
  - Required: writes addr0=0x00100513 and addr1=0x00200593; then 0xAA; then `boot_done`=1.
- Size 0:
  - Stimulus: size bytes 00 00 00 00.
  - Required: no write strobe; 0xAA offered the cycle after the 4th byte; then `boot_done`.
- Partial word:
  - Stimulus: size 6; bytes 11 22 33 44 55 66.
  - Required: addr0=0x44332211; addr1=0x00006655; then 0xAA.
- Transmit stall:
  - Stimulus: hold `tx_ready`=0 for 10 cycles during SEND_99.
  - Required: `tx_valid`=1 and `tx_data`=0x99 stable throughout; exactly one transfer when `tx_ready` rises.
- Overflow:
  - Stimulus: W=2, size 20 bytes.
  - Required: 4 writes (addr 0–3); `overflow`=1 after the 5th word; the 5th write is suppressed; 0xAA still sent; `restart` clears `overflow` and 0x99 is re-sent.
- Reset mid-load:
  - Stimulus: assert `reset_n`=0 after 3 program bytes, then release.
  - Required: all outputs take reset values immediately; 0x99 is re-sent; a fresh load from addr 0 succeeds.
